// File: rtl/wb_manager_interface.sv
// Wishbone B4 pipelined manager: one command in, one single-beat bus transaction, one response out.
// A per-transaction cycle budget aborts transfers to absent or hung subordinates.
module wb_manager_interface #(
  parameter int WB_ADDRESS_WIDTH    = 32,
  parameter int WB_DATA_WIDTH       = 32,
  parameter int WB_DATA_GRANULARITY = 8,
  parameter int WB_SEL_WIDTH        = WB_DATA_WIDTH / WB_DATA_GRANULARITY,
  parameter int TIMEOUT_CYCLES      = 256
) (
  input  logic                        i_wb_clk,
  input  logic                        i_wb_rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_we,
  input  logic [WB_ADDRESS_WIDTH-1:0] i_cmd_addr,
  input  logic [WB_DATA_WIDTH-1:0]    i_cmd_wdata,
  input  logic [WB_SEL_WIDTH-1:0]     i_cmd_sel,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]    o_rsp_rdata,
  output logic                        o_rsp_err,
  output logic                        o_rsp_timeout,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic                        o_wb_we,
  output logic [WB_ADDRESS_WIDTH-1:0] o_wb_addr,
  output logic [WB_DATA_WIDTH-1:0]    o_wb_dat,
  output logic [WB_SEL_WIDTH-1:0]     o_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0]    i_wb_dat,
  input  logic                        i_wb_stall,
  input  logic                        i_wb_ack,
  input  logic                        i_wb_err,
  output logic [1:0]                  o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     cmd_ready_d, cyc_d, stb_d;
  logic                     rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [WB_DATA_WIDTH-1:0] rsp_rdata_d;
  logic                     accept;
  logic                     bus_done;

  // Both streams transfer on a clock edge where valid and ready are both high; valid, once raised,
  // holds its payload stable until that edge, and ready never depends combinationally on valid.
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign bus_done    = i_wb_ack | i_wb_err;
  assign o_dbg_state = state_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = o_cmd_ready;
    cyc_d         = o_wb_cyc;
    stb_d         = o_wb_stb;
    rsp_valid_d   = o_rsp_valid;
    rsp_err_d     = o_rsp_err;
    rsp_timeout_d = o_rsp_timeout;
    rsp_rdata_d   = o_rsp_rdata;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_REQ;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
        end
      end
      ST_REQ, ST_WAIT: begin
        // A termination only counts once the strobe has been taken (not stalled).
        if (bus_done && (state_q == ST_WAIT || !i_wb_stall)) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = i_wb_err;
          rsp_rdata_d = (i_wb_err || o_wb_we) ? '0 : i_wb_dat;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_RESP;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == ST_REQ && !i_wb_stall) begin
            state_d = ST_WAIT;
            stb_d   = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d       = ST_IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      o_cmd_ready   <= 1'b1;
      o_wb_cyc      <= 1'b0;
      o_wb_stb      <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
      o_rsp_rdata   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      o_cmd_ready   <= cmd_ready_d;
      o_wb_cyc      <= cyc_d;
      o_wb_stb      <= stb_d;
      o_rsp_valid   <= rsp_valid_d;
      o_rsp_err     <= rsp_err_d;
      o_rsp_timeout <= rsp_timeout_d;
      o_rsp_rdata   <= rsp_rdata_d;
    end
  end

  // Bus request fields load only on command accept, so they stay frozen through any stall.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_dat  <= '0;
      o_wb_sel  <= '0;
    end else if (accept) begin
      o_wb_we   <= i_cmd_we;
      o_wb_addr <= i_cmd_addr;
      o_wb_dat  <= i_cmd_wdata;
      o_wb_sel  <= i_cmd_sel;
    end
  end

endmodule

// File: tb/tb_wb_manager_interface.sv
// Bench for wb_manager_interface: transaction-level timing model (edge offsets from accept) checked every cycle,
// plus literal pins on directed transactions and an asynchronous reset in the middle of a transfer.
module tb_wb_manager_interface;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          i_cmd_valid, o_cmd_ready, i_cmd_we;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic [SW-1:0] i_cmd_sel;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_err, o_rsp_timeout;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_dat;
  logic [SW-1:0] o_wb_sel;
  logic [DW-1:0] i_wb_dat;
  logic          i_wb_stall, i_wb_ack, i_wb_err;
  logic [1:0]    dbg_state;

  wb_manager_interface #(
    .WB_ADDRESS_WIDTH(AW), .WB_DATA_WIDTH(DW), .WB_DATA_GRANULARITY(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_sel(i_cmd_sel),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .i_wb_dat(i_wb_dat),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_dbg_state(dbg_state)
  );

  // expected outputs for the current cycle
  logic          e_cyc, e_stb, e_ready, e_rvalid, e_err, e_to, e_we;
  logic [DW-1:0] e_rdata, e_dat;
  logic [AW-1:0] e_addr;
  logic [SW-1:0] e_sel;
  bit            chk_en  = 1'b0;
  bit            lit_req = 1'b0;
  string         lit_name;
  logic [63:0]   lit_act, lit_exp;
  int            vectors = 0;
  int            miscompares = 0;

  // observations of the last transaction
  int            m_stb_cnt, m_valid_cnt, m_lat;
  logic [DW-1:0] m_rdata;
  logic          m_err, m_to;

  task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // scoreboard: the single compare process
  always @(negedge clk) begin
    if (lit_req) cmp(lit_name, lit_act, lit_exp);
    if (chk_en) begin
      cmp("cmd_ready", 64'(o_cmd_ready), 64'(e_ready));
      cmp("wb_cyc", 64'(o_wb_cyc), 64'(e_cyc));
      cmp("wb_stb", 64'(o_wb_stb), 64'(e_stb));
      cmp("rsp_valid", 64'(o_rsp_valid), 64'(e_rvalid));
      cmp("rsp_rdata", 64'(o_rsp_rdata), 64'(e_rdata));
      cmp("rsp_err", 64'(o_rsp_err), 64'(e_err));
      cmp("rsp_timeout", 64'(o_rsp_timeout), 64'(e_to));
      if (e_stb) begin
        cmp("wb_we", 64'(o_wb_we), 64'(e_we));
        cmp("wb_addr", 64'(o_wb_addr), 64'(e_addr));
        cmp("wb_dat", 64'(o_wb_dat), 64'(e_dat));
        cmp("wb_sel", 64'(o_wb_sel), 64'(e_sel));
      end
    end
  end

  task automatic pin(input string nm, input logic [63:0] a, input logic [63:0] e);
    lit_name = nm;
    lit_act  = a;
    lit_exp  = e;
    lit_req  = 1'b1;
    @(negedge clk);
    #1 lit_req = 1'b0;
  endtask

  task automatic set_idle();
    e_cyc = 0; e_stb = 0; e_ready = 1; e_rvalid = 0; e_rdata = '0; e_err = 0; e_to = 0;
  endtask

  task automatic junk_inputs();
    i_wb_stall  = 1'($urandom_range(0, 1));
    i_wb_ack    = 1'($urandom_range(0, 1));
    i_wb_err    = 1'($urandom_range(0, 1));
    i_wb_dat    = $urandom();
    i_rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // kind: 0 none, 1 ack, 2 err, 3 ack+err; s stall edges; d edges from strobe acceptance to termination;
  // r cycles with rsp_ready low; gap idle cycles before the command.
  task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] sel, input logic [DW-1:0] rd, input int s, input int d,
                         input int kind, input int r, input int gap, input bit stray);
    int a, c, last, j;
    bit timed, has_err;
    a       = s + 1 + d;
    timed   = (kind == 0) || (a > TO);
    has_err = (kind >= 2);
    c       = timed ? TO : a;
    last    = c + 1 + r;
    m_stb_cnt = 0; m_valid_cnt = 0; m_lat = -1; m_rdata = '0; m_err = 0; m_to = 0;
    e_we = we; e_addr = addr; e_dat = wdata; e_sel = sel;
    for (int g = 0; g < gap; g++) begin
      i_cmd_valid = 1'b0;
      junk_inputs();
      @(posedge clk); #1;
    end
    i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_addr = addr; i_cmd_wdata = wdata; i_cmd_sel = sel;
    junk_inputs();
    @(posedge clk); #1;
    for (int k = 0; k <= last; k++) begin
      if (k < c) begin
        e_cyc = 1; e_stb = (k <= s); e_ready = 0; e_rvalid = 0; e_rdata = '0; e_err = 0; e_to = 0;
      end else if (k <= c + r) begin
        e_cyc = 0; e_stb = 0; e_ready = 0; e_rvalid = 1;
        e_err = !timed && has_err;
        e_to = timed;
        e_rdata = (timed || has_err || we) ? '0 : rd;
      end else begin
        set_idle();
      end
      if (o_wb_stb) m_stb_cnt++;
      if (o_rsp_valid) begin
        m_valid_cnt++;
        if (m_lat < 0) begin
          m_lat = k; m_rdata = o_rsp_rdata; m_err = o_rsp_err; m_to = o_rsp_timeout;
        end
      end
      if (k < last) begin
        j = k + 1;
        i_cmd_valid = 1'($urandom_range(0, 1));
        i_cmd_we    = 1'($urandom_range(0, 1));
        i_cmd_addr  = $urandom();
        i_cmd_wdata = $urandom();
        i_cmd_sel   = SW'($urandom());
        i_wb_stall  = (j <= s) ? 1'b1 : (j == s + 1) ? 1'b0 : 1'($urandom_range(0, 1));
        i_wb_dat    = (j == a) ? rd : $urandom();
        if (j <= s) begin
          i_wb_ack = stray & 1'($urandom_range(0, 1));
          i_wb_err = stray & 1'($urandom_range(0, 1));
        end else if (j == a && kind != 0) begin
          i_wb_ack = (kind == 1 || kind == 3);
          i_wb_err = (kind == 2 || kind == 3);
        end else if (j > c) begin
          i_wb_ack = 1'($urandom_range(0, 1));
          i_wb_err = 1'($urandom_range(0, 1));
        end else begin
          i_wb_ack = 1'b0;
          i_wb_err = 1'b0;
        end
        i_rsp_ready = (k == c + r) ? 1'b1 : (k < c) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end else begin
        i_cmd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic a_cyc, a_stb, a_rv, a_rdy, w_cyc, w_stb;
    int v, kind, d, r;
    rst_n = 1'b1;
    i_cmd_valid = 0; i_cmd_we = 0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_sel = '0;
    i_rsp_ready = 0; i_wb_dat = '0; i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0;
    e_we = 0; e_addr = '0; e_dat = '0; e_sel = '0;
    #1 rst_n = 1'b0;
    set_idle();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // read, no stall, ack one cycle after the strobe
    run_txn(0, 32'h4001_0008, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 1, 1, 0, 1, 0);
    pin("rd_stb_cycles", 64'(m_stb_cnt), 64'd1);
    pin("rd_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    pin("rd_latency", 64'(m_lat), 64'd2);
    pin("rd_flags", {62'd0, m_err, m_to}, 64'd0);

    // write with three stall cycles
    run_txn(1, 32'h0000_1234, 32'hA5A5_5A5A, 4'b0011, 32'hFFFF_FFFF, 3, 1, 1, 0, 0, 1);
    pin("wr_stb_cycles", 64'(m_stb_cnt), 64'd4);
    pin("wr_rdata", 64'(m_rdata), 64'd0);
    pin("wr_latency", 64'(m_lat), 64'd5);

    // err together with ack
    run_txn(0, 32'h0000_0100, 32'h0, 4'hF, 32'h1234_5678, 0, 2, 3, 0, 1, 0);
    pin("err_flag", 64'(m_err), 64'd1);
    pin("err_rdata", 64'(m_rdata), 64'd0);

    // no termination inside the budget; ack arrives late
    run_txn(0, 32'h0000_0200, 32'h0, 4'hF, 32'hCAFE_F00D, 0, 10, 1, 4, 0, 0);
    pin("to_flag", 64'(m_to), 64'd1);
    pin("to_latency", 64'(m_lat), 64'd8);
    pin("to_rdata", 64'(m_rdata), 64'd0);

    // response backpressure for five cycles
    run_txn(0, 32'h0000_0300, 32'h0, 4'hF, 32'h0BAD_F00D, 1, 0, 1, 5, 2, 1);
    pin("bp_valid_cycles", 64'(m_valid_cnt), 64'd6);
    pin("bp_stb_cycles", 64'(m_stb_cnt), 64'd2);
    pin("bp_rdata", 64'(m_rdata), 64'h0BAD_F00D);

    // asynchronous reset while waiting for termination
    chk_en = 1'b0;
    i_cmd_valid = 1; i_cmd_we = 0; i_cmd_addr = 32'h0000_0400; i_cmd_wdata = '0; i_cmd_sel = 4'hF;
    i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_rsp_ready = 0;
    @(posedge clk); #1;
    i_cmd_valid = 0;
    @(posedge clk); #1;
    w_cyc = o_wb_cyc; w_stb = o_wb_stb;
    #1 rst_n = 1'b0;
    #1;
    a_cyc = o_wb_cyc; a_stb = o_wb_stb; a_rv = o_rsp_valid; a_rdy = o_cmd_ready;
    pin("wait_cyc", 64'(w_cyc), 64'd1);
    pin("wait_stb", 64'(w_stb), 64'd0);
    pin("rst_cyc", 64'(a_cyc), 64'd0);
    pin("rst_stb", 64'(a_stb), 64'd0);
    pin("rst_rsp_valid", 64'(a_rv), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    a_cyc = o_wb_cyc; a_rv = o_rsp_valid; a_rdy = o_cmd_ready;
    pin("post_rst_ready", 64'(a_rdy), 64'd1);
    pin("post_rst_cyc", 64'(a_cyc), 64'd0);
    pin("post_rst_rsp_valid", 64'(a_rv), 64'd0);
    set_idle();
    chk_en = 1'b1;

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      v = $urandom_range(0, 9);
      kind = (v == 0) ? 0 : (v <= 5) ? 1 : (v <= 7) ? 2 : 3;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
      r = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), SW'($urandom()), $urandom(),
              $urandom_range(0, 3), d, kind, r, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
